// File: rtl/wbuf_read_sched.sv
// Read scheduler for the 6-bank dual-port weight buffer: arbitrates four lane
// requests onto bank ports A/B with rotating priority and aligns response strobes to read data.
module wbuf_read_sched #(
  parameter int N_BANK = 6,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BANK_W = $clog2(N_BANK),
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [3:0]             req_valid,
  input  logic [3:0][BANK_W-1:0] req_bank,
  input  logic [3:0][ADDR_W-1:0] req_addr,
  output logic [3:0]             req_ready,
  output logic [3:0][BANK_W-1:0] bank_sel,
  output logic [3:0][ADDR_W-1:0] addr_sel,
  output logic [3:0]             en_sel,
  output logic [3:0]             port_sel,
  output logic [3:0]             rsp_valid,
  output logic [3:0]             rsp_err,
  output logic [15:0]            conflict_cnt
);

  // Handshake: a lane transfers when req_valid & req_ready are both high at the
  // rising edge; the lane holds req_bank/req_addr while valid and not ready.
  // req_ready is combinational and depends on all lanes' req_valid.

  logic [1:0]        ptr;
  logic [3:0]        legal;
  logic [3:0]        grant;
  logic [3:0]        gport;
  logic [3:0]        acc_err;
  logic              stall;
  logic [N_BANK-1:0] a_busy;
  logic [N_BANK-1:0] b_busy;
  logic [1:0]        lane;

  // Stage 0 lines up with en_sel; stage RD_LAT lines up with WBUF read data.
  logic [3:0] pv [RD_LAT+1];
  logic [3:0] pe [RD_LAT+1];

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      legal[j] = (32'(req_bank[j]) < N_BANK) && (32'(req_addr[j]) < DEPTH);
    end
  end

  always_comb begin
    a_busy    = '0;
    b_busy    = '0;
    req_ready = '0;
    grant     = '0;
    gport     = '0;
    acc_err   = '0;
    stall     = 1'b0;
    lane      = '0;
    for (int k = 0; k < 4; k++) begin
      lane = ptr + 2'(k);
      if (req_valid[lane] && rst_n && !clear) begin
        if (!legal[lane]) begin
          req_ready[lane] = 1'b1;
          acc_err[lane]   = 1'b1;
        end else if (!a_busy[req_bank[lane]]) begin
          a_busy[req_bank[lane]] = 1'b1;
          req_ready[lane]        = 1'b1;
          grant[lane]            = 1'b1;
        end else if (!b_busy[req_bank[lane]]) begin
          b_busy[req_bank[lane]] = 1'b1;
          req_ready[lane]        = 1'b1;
          grant[lane]            = 1'b1;
          gport[lane]            = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      bank_sel     <= '0;
      addr_sel     <= '0;
      en_sel       <= '0;
      port_sel     <= '0;
      conflict_cnt <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pv[i] <= '0;
        pe[i] <= '0;
      end
    end else if (clear) begin
      ptr          <= '0;
      bank_sel     <= '0;
      addr_sel     <= '0;
      en_sel       <= '0;
      port_sel     <= '0;
      conflict_cnt <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pv[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      if (|grant) ptr <= ptr + 2'd1;
      if (stall && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      for (int j = 0; j < 4; j++) begin
        bank_sel[j] <= grant[j] ? req_bank[j] : '0;
        addr_sel[j] <= grant[j] ? req_addr[j] : '0;
      end
      en_sel   <= grant;
      port_sel <= gport & grant;
      // Illegal accepts ride the same pipeline so per-lane responses stay ordered.
      pv[0] <= grant | acc_err;
      pe[0] <= acc_err;
      for (int i = 1; i <= RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  assign rsp_valid = pv[RD_LAT];
  assign rsp_err   = pe[RD_LAT];

endmodule

// File: doc/wbuf_read_sched.md
# wbuf_read_sched

Read scheduler/arbiter in front of the 6-bank true-dual-port weight buffer. It accepts up to four independent block-read requests per cycle, one per systolic-array lane, and maps each accepted request onto a free bank port (A, then B). It drives the buffer's registered select interface and returns a per-lane response-valid strobe aligned to the buffer's read data. Each bank serves at most two reads per cycle; the other lanes stall. Rotating priority guarantees no lane starves.

## Interface
- N_BANK, 6, number of WBUF banks
- DEPTH, 11, blocks per bank (legal addr 0..DEPTH-1)
- ADDR_W, $clog2(DEPTH)=4, block address width
- BANK_W, $clog2(N_BANK)=3, bank index width
- RD_LAT, 2, cycles from en_sel high to valid WBUF data (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of pointer, pipeline and counter
- req_valid  in  [3:0]  per-lane read request
- req_bank  in  [3:0][BANK_W-1:0]  requested bank
- req_addr  in  [3:0][ADDR_W-1:0]  requested block address
- req_ready  out  [3:0]  request accepted this cycle (combinational)
- bank_sel  out  [3:0][BANK_W-1:0]  to WBUF, registered
- addr_sel  out  [3:0][ADDR_W-1:0]  to WBUF, registered
- en_sel  out  [3:0]  to WBUF, registered
- port_sel  out  [3:0]  to WBUF, 0=A 1=B, registered
- rsp_valid  out  [3:0]  WBUF dout_sel[j] valid this cycle
- rsp_err  out  [3:0]  qualifies rsp_valid: request was illegal, data is don't-care
- conflict_cnt  out  16  saturating count of cycles with a legal request stalled

## Operation
- Legal request: req_bank < N_BANK and req_addr < DEPTH. Illegal requests are accepted immediately (req_ready=1) and consume no port. They are answered with rsp_err=1.
- Arbitration (combinational, each cycle): visit lanes in order ptr, ptr+1, … (mod 4). For each valid legal lane: grant port A of its bank if it is still free; else grant port B if it is still free; else req_ready=0.
- Two lanes with the same bank and the same address still occupy two ports. There is no merging.
- ptr (2-bit) advances by 1 mod 4 at each clock edge where at least one legal grant occurred. It holds otherwise.
- The lane at ptr is always granted when it is valid. Any continuously-valid lane is therefore granted within 4 granting cycles.
- Output register, per lane j:
  - On a legal grant: en_sel[j]=1, bank_sel[j]=req_bank[j], addr_sel[j]=req_addr[j], port_sel[j]=granted port.
  - Otherwise: en_sel[j]=0 and the other three fields are 0.
- Response pipeline: a per-lane shift register of depth RD_LAT carries {valid, err}.
  - A legal grant enters as {1,0}. An illegal accept enters as {1,1}.
  - Each entry emerges on rsp_valid/rsp_err RD_LAT cycles after the corresponding en_sel cycle, i.e. 1+RD_LAT cycles after the handshake.
  - An illegal accept emerges at the same position in the pipeline, so per-lane responses stay in order.
- conflict_cnt increments by 1 in any cycle where some valid legal lane has req_ready=0. It saturates at 0xFFFF.
- clear (takes priority over traffic):
  - req_ready forced to 0.
  - At the next edge: ptr=0, output register zeroed, response pipeline zeroed, conflict_cnt=0.
  - In-flight reads are discarded and produce no rsp_valid.

## Timing
- Reset values: req_ready=0 while rst_n is low; bank_sel=addr_sel=0, en_sel=0, port_sel=0, rsp_valid=0, rsp_err=0, conflict_cnt=0, ptr=0.
- Handshake: the transfer occurs when req_valid & req_ready are high at the clock edge. The requester must hold req_bank/req_addr stable while valid and not ready. req_ready may depend on req_valid of all lanes.
- Throughput: up to 4 grants per cycle when the lanes hit ≥2 distinct banks with ≤2 lanes per bank.
- Latency: handshake at edge t → en_sel high in cycle t+1 → rsp_valid high in cycle t+1+RD_LAT, in the same cycle as the WBUF dout_sel data.
- Reset asserted mid-operation clears everything asynchronously. No stale rsp_valid appears after reset is released.

## Test plan
- Four lanes, banks 0,1,2,3, addr 5, ptr=0 → all ready in the same cycle; next cycle en_sel=4'b1111, port_sel=4'b0000; rsp_valid=4'b1111 exactly 3 cycles after the handshake (RD_LAT=2).
- All four lanes hit bank 4 (addr 0..3) and are held valid, ptr=0 → cycle 1 grants lanes 0(A) and 1(B); cycle 2 grants lanes 2(A) and 3(B). conflict_cnt=1. ptr advances once per granting cycle.
- Lane 2 requests bank 7, or addr 12 → ready in the same cycle, en_sel[2]=0, rsp_valid[2]=1 with rsp_err[2]=1 three cycles later; no bank port is consumed.
- Starvation check: lanes 0–3 continuously request bank 1 for 20 cycles → each lane is granted at least once in every 4 consecutive cycles, and rsp_valid count per lane equals its grant count.
- clear pulsed while 4 reads are in flight → rsp_valid stays 0 for the following RD_LAT+1 cycles; conflict_cnt=0; ptr=0.
- rst_n dropped asynchronously mid-burst → all outputs 0 immediately. After release, a single lane-3 request to bank 0, addr 10 yields port_sel[3]=0 and rsp_valid[3] 3 cycles later.
